// File: rtl/data_mem.sv
// Data-side memory responder: word RAM below 0xF800, plus a small I/O page with a
// TX byte FIFO (valid/ready drain), a STATUS register and a free-running step counter.
module data_mem #(
   parameter int RAM_AW     = 11,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_stb_800k,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_out,
   input  logic        mem_write_en,
   output logic [15:0] data_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int         PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

   logic [15:0]       ram [0:(1<<RAM_AW)-1];
   logic [7:0]        fifo_mem [0:FIFO_DEPTH-1];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [3:0]        count;
   logic              overflow;
   logic [15:0]       ticks;

   logic [RAM_AW-1:0] ram_idx;
   logic              is_ram, is_tx, is_stat, is_ticks;
   logic              commit, empty, full, pop, push_req, push_ok, ov_clr;
   logic [15:0]       io_rd;
   logic [15:0]       ram_q, io_q;
   logic              sel_ram_q;

   assign ram_idx  = data_addr[RAM_AW-1:0];
   assign is_ram   = (data_addr < 16'hF800);
   assign is_tx    = (data_addr == 16'hF800);
   assign is_stat  = (data_addr == 16'hF801);
   assign is_ticks = (data_addr == 16'hF802);

   // A store lands only on the strobe clk, so each CPU step commits at most once.
   assign commit   = mem_write_en & clk_stb_800k;
   assign empty    = (count == 4'd0);
   assign full     = (count == DEPTH);
   assign pop      = ~empty & tx_ready;
   assign push_req = commit & is_tx;
   assign push_ok  = push_req & (~full | pop);
   assign ov_clr   = commit & is_stat & data_out[2];

   assign tx_valid = ~empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

   always_comb begin
      io_rd = 16'h0000;
      if (is_stat)
         io_rd = {8'h00, count, 1'b0, overflow, full, empty};
      else if (is_ticks)
         io_rd = ticks;
   end

   // RAM has no reset; its read port is registered every clk and returns the old
   // word on a same-index write.
   always_ff @(posedge clk) begin
      if (!rst && commit && is_ram)
         ram[ram_idx] <= data_out;
      ram_q <= ram[ram_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_q      <= 16'h0000;
         sel_ram_q <= 1'b0;
      end else begin
         io_q      <= io_rd;
         sel_ram_q <= is_ram;
      end
   end

   assign data_in = sel_ram_q ? ram_q : io_q;

   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         fifo_mem[wr_ptr] <= data_out[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= 4'd0;
         overflow <= 1'b0;
         ticks    <= 16'h0000;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
         // A rejected push in the same clk as a clear leaves overflow set.
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (ov_clr)
            overflow <= 1'b0;
         if (commit && is_ticks)
            ticks <= data_out;
         else if (clk_stb_800k)
            ticks <= ticks + 16'd1;
      end
   end

endmodule

// File: doc/data_mem.md
# data_mem

Data-side memory responder for the CPU: services every load, store, push and pop the core issues on its data port, backed by word RAM plus a small memory-mapped I/O page. Sits between the core's `data_addr`/`data_out`/`mem_write_en`/`data_in` signals and the board-level serial transmitter. It commits each CPU store exactly once per CPU step and drains a byte FIFO to the transmitter over a valid/ready handshake.

## Interface
- `RAM_AW`, 11: RAM address width; RAM holds 2^RAM_AW 16-bit words.
- `FIFO_DEPTH`, 8: TX FIFO depth; power of two, 2..8.
- `clk` input 1: system clock, shared with the CPU.
- `rst` input 1: reset. Synchronous and active-high.
- `clk_stb_800k` input 1: one-`clk` CPU step strobe, shared with the CPU.
- `data_addr` input 16: CPU data address.
- `data_out` input 16: CPU store data.
- `mem_write_en` input 1: CPU store request; held high for the whole CPU step.
- `data_in` output 16: registered read data to the CPU.
- `tx_data` output 8: FIFO head byte.
- `tx_valid` output 1: FIFO non-empty.
- `tx_ready` input 1: transmitter accepts `tx_data` this `clk`.

## Operation
- Address map:
  - `0x0000`–`0xF7FF`: RAM, indexed by `data_addr[RAM_AW-1:0]`. Aliasing is intended; stack top `0xF7FF` maps to index `2^RAM_AW-1`.
  - `0xF800` TXDATA:
    - Write pushes `data_out[7:0]`.
    - Read returns 0.
  - `0xF801` STATUS:
    - Read returns `{8'b0, count[3:0], 1'b0, overflow, full, empty}`.
    - A write with `data_out[2]=1` clears `overflow`. Other bits are ignored.
  - `0xF802` TICKS:
    - Read returns the 16-bit step counter.
    - Write loads it with `data_out`.
  - `0xF803`–`0xFFFF`: reads 0, writes ignored.
- Store commit:
  - A store takes effect only on a `clk` where `mem_write_en && clk_stb_800k`.
  - With `mem_write_en` high and no strobe, nothing changes.
  - This guarantees exactly one push/RAM write per CPU step.
- Reads:
  - `data_in` is re-registered on every `clk` from the current `data_addr`, using pre-edge state of RAM, FIFO and counters.
  - On a RAM read-during-write to the same index, `data_in` returns the old word.
- FIFO:
  - `tx_valid = ~empty`. `tx_data` = head entry.
  - Pop occurs when `tx_valid && tx_ready`.
  - A push is accepted when `count < FIFO_DEPTH`, or when a pop occurs on the same `clk`.
  - A rejected push sets sticky `overflow` and leaves the FIFO unchanged.
  - Simultaneous accepted push and pop leave `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. `count` runs 0..`FIFO_DEPTH`.
  - `empty = (count==0)`. `full = (count==FIFO_DEPTH)`.
- TICKS:
  - Increments by 1 (mod 2^16) on every `clk_stb_800k`.
  - A committed write on the same `clk` wins over the increment.
- Overflow clear vs set on the same `clk`: the set wins.

## Timing
- Reset (`rst`=1 at a `clk` edge) produces:
  - `data_in`=0, `tx_valid`=0, `tx_data`=0.
  - FIFO empty, pointers 0, `overflow`=0, TICKS=0.
  - RAM contents are not cleared.
- During reset, stores, pops and strobes are ignored.
- Reset mid-operation discards queued bytes. `tx_valid` drops on the first `clk` after the reset edge.
- Read latency: 1 `clk` from address to `data_in`.
  - The CPU's address changes only after a strobe, and strobes are at least 2 `clk` apart.
  - Therefore `data_in` is valid before the next strobe.
- Store visibility: a value written on strobe edge N is readable on `data_in` one `clk` after edge N (same address held).
- `tx_valid` rises 1 `clk` after the accepting push edge.
- `tx_data` advances to the next entry 1 `clk` after each pop edge.
- No combinational path from `tx_ready` to `tx_valid`, or from `data_addr` to `data_in`.

## Test plan
- **RAM write/read:** store `0x1234` to `0x0010`, then to `0xF7FF`, with strobes.
  - Reads return `0x1234`.
  - Reading `0x07FF` (RAM_AW=11) also returns the `0xF7FF` value.
- **Single commit:** hold `mem_write_en`=1 to TXDATA with `0x41` for 5 `clk` containing one strobe, `tx_ready`=0.
  - STATUS reads count=1.
  - Exactly one `0x41` appears on `tx_data`.
- **Overflow:** with `tx_ready`=0, push 9 bytes `0x00`..`0x08`.
  - STATUS = `0x0086` (count=8, overflow, full).
  - Draining yields `0x00`..`0x07` in order; byte `0x08` is lost.
  - Writing STATUS with `0x0004` clears overflow.
- **Push while full with pop:** FIFO full, `tx_ready`=1 on the strobe edge pushing `0x55`.
  - Push is accepted, count stays 8, overflow stays 0.
  - `0x55` is the last byte out.
- **TICKS:** reset, then 3 strobes; read TICKS = 3.
  - Write `0xFFFF` on a strobe; the next strobe gives TICKS = `0x0000`.
- **Reset mid-drain:** 4 bytes queued, assert `rst` for 1 `clk`.
  - `tx_valid`=0, STATUS=`0x0001`, TICKS=0.
  - A previously written RAM word is still readable.
